branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 The module SHALL have parameter BTB_ADDR_LEN, default 7, giving the index width; the table SHALL hold 2^BTB_ADDR_LEN entries.
REQ-002 The module SHALL have parameter PC_LEN, default 32, giving the PC and target width.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pc_if  input  PC_LEN  fetch-stage PC to look up.
REQ-006 predict_taken  input  1  direction prediction from the branch history table for pc_if.
REQ-007 btb_hit  output  1  a valid entry with a matching tag exists for pc_if.
REQ-008 pred_jump  output  1  equals btb_hit AND predict_taken.
REQ-009 pred_target  output  PC_LEN  stored target on a hit, else 0.
REQ-010 ex_is_br  input  1  the execute stage holds a resolved conditional branch this cycle.
REQ-011 pc_ex  input  PC_LEN  PC of the resolved branch.
REQ-012 br_ex  input  1  actual direction, 1 = taken.
REQ-013 br_target_ex  input  PC_LEN  actual taken target.
REQ-014 ex_pred_jump  input  1  pred_jump value carried down the pipe with this branch.
REQ-015 ex_pred_target  input  PC_LEN  pred_target value carried down the pipe with this branch.
REQ-016 btb_clear  input  1  synchronous request to invalidate all entries.
REQ-017 mispredict  output  1  the resolved branch was mispredicted; flush IF/ID.
REQ-018 redirect_pc  output  PC_LEN  correct next PC when mispredict = 1, else 0.

Function
REQ-019 Index SHALL be pc[BTB_ADDR_LEN+1:2]; tag SHALL be pc[PC_LEN-1:BTB_ADDR_LEN+2]. Each entry SHALL hold a valid bit, a tag and a target.
REQ-020 Lookup SHALL be combinational, with zero-cycle latency from pc_if. A write in the same cycle SHALL NOT bypass; lookup returns the pre-edge contents.
REQ-021 When ex_is_br=1 and br_ex=1, the entry at index(pc_ex) SHALL be written with valid=1, tag(pc_ex) and br_target_ex. Any conflicting entry SHALL be replaced (direct-mapped).
REQ-022 When ex_is_br=1 and br_ex=0, the table SHALL be unchanged.
REQ-023 mispredict SHALL be combinational and equal ex_is_br AND (ex_pred_jump != br_ex OR (ex_pred_jump AND br_ex AND ex_pred_target != br_target_ex)).
REQ-024 When mispredict=1, redirect_pc SHALL be br_target_ex if br_ex=1, else pc_ex+4 (modulo 2^PC_LEN, wrapping silently).
REQ-025 btb_clear=1 SHALL clear every valid bit at the next edge. If btb_clear and a write coincide, clear SHALL win and no entry is valid afterwards.
REQ-026 With ex_is_br=0, the other ex_* inputs SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL immediately clear all valid bits. Tags and targets are don't-care.
REQ-028 During reset, btb_hit, pred_jump and pred_target SHALL read 0. mispredict and redirect_pc follow REQ-023/024 from their inputs.
REQ-029 An update coinciding with reset assertion SHALL be lost. The first write SHALL occur on the first rising edge after rst_n=1.

Configuration
REQ-030 Macro BTB_STATS_EN SHALL compile in the outputs stat_br_cnt and stat_miss_cnt, both 32 bits and reset to 0.
REQ-031 With BTB_STATS_EN defined:
- stat_br_cnt SHALL increment on each edge with ex_is_br=1.
- stat_miss_cnt SHALL increment on each edge with mispredict=1.
- Both SHALL wrap from 0xFFFFFFFF to 0.
- Both SHALL be unaffected by btb_clear.
REQ-032 Without BTB_STATS_EN, the ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset, then pc_if=0x100, predict_taken=1 -> btb_hit=0, pred_jump=0, pred_target=0.
REQ-034 Resolve taken branch pc_ex=0x100, br_target_ex=0x40, ex_pred_jump=0 -> mispredict=1, redirect_pc=0x40. The next cycle, pc_if=0x100 with predict_taken=1 gives btb_hit=1, pred_jump=1, pred_target=0x40.
REQ-035 Resolve pc_ex=0x100, br_ex=0, ex_pred_jump=1 -> mispredict=1, redirect_pc=0x104, and the entry is retained (btb_hit=1 for 0x100).
REQ-036 Alias pc_ex=0x300 (same index as 0x100, BTB_ADDR_LEN=7), taken to 0x80 -> lookup 0x100 misses, and lookup 0x300 hits with 0x80.
REQ-037 btb_clear=1 coinciding with a taken update at 0x200 -> lookups at 0x100 and 0x200 both miss the next cycle.
REQ-038 With BTB_STATS_EN defined, 5 resolved branches including 2 mispredicts -> stat_br_cnt=5, stat_miss_cnt=2. A pulse on rst_n=0 returns both to 0.

Source files
------------

// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch lookup and execute resolve signals of the branch target buffer
interface branch_target_buffer_if #(
  parameter int PC_LEN = 32
);
  // Fetch-stage lookup
  logic [PC_LEN-1:0] pc_if;
  logic              predict_taken;
  logic              btb_hit;
  logic              pred_jump;
  logic [PC_LEN-1:0] pred_target;

  // Execute-stage resolution
  logic              ex_is_br;
  logic [PC_LEN-1:0] pc_ex;
  logic              br_ex;
  logic [PC_LEN-1:0] br_target_ex;
  logic              ex_pred_jump;
  logic [PC_LEN-1:0] ex_pred_target;
  logic              btb_clear;
  logic              mispredict;
  logic [PC_LEN-1:0] redirect_pc;

  modport master (
    output pc_if, predict_taken,
    output ex_is_br, pc_ex, br_ex, br_target_ex, ex_pred_jump, ex_pred_target, btb_clear,
    input  btb_hit, pred_jump, pred_target, mispredict, redirect_pc
  );

  modport slave (
    input  pc_if, predict_taken,
    input  ex_is_br, pc_ex, br_ex, br_target_ex, ex_pred_jump, ex_pred_target, btb_clear,
    output btb_hit, pred_jump, pred_target, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with misprediction detection; optional counters via BTB_STATS_EN
module branch_target_buffer #(
  parameter int BTB_ADDR_LEN = 7,
  parameter int PC_LEN       = 32
) (
  input  logic clk,
  input  logic rst_n,
  branch_target_buffer_if.slave bus
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_br_cnt,
  output logic [31:0] stat_miss_cnt
`endif
);

  localparam int ENTRIES = 1 << BTB_ADDR_LEN;
  localparam int TAG_LEN = PC_LEN - BTB_ADDR_LEN - 2;

  // Only valid bits need reset; tag/target contents are meaningless while invalid.
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] valid_d;
  logic [TAG_LEN-1:0] tag_q    [ENTRIES];
  logic [PC_LEN-1:0]  target_q [ENTRIES];

  logic [BTB_ADDR_LEN-1:0] if_idx;
  logic [TAG_LEN-1:0]      if_tag;
  logic [BTB_ADDR_LEN-1:0] ex_idx;
  logic [TAG_LEN-1:0]      ex_tag;
  logic                    wr_en;
  logic                    hit;
  logic                    dir_wrong;
  logic                    tgt_wrong;
  logic                    mispredict;

  // Byte offset bits never select an entry: instructions are word aligned.
  logic unused_pc_low_bits;
  assign unused_pc_low_bits = ^{bus.pc_if[1:0], bus.pc_ex[1:0]};

  assign if_idx = bus.pc_if[BTB_ADDR_LEN+1:2];
  assign if_tag = bus.pc_if[PC_LEN-1:BTB_ADDR_LEN+2];
  assign ex_idx = bus.pc_ex[BTB_ADDR_LEN+1:2];
  assign ex_tag = bus.pc_ex[PC_LEN-1:BTB_ADDR_LEN+2];

  // Lookup reads registered contents only, so a same-cycle write is not visible.
  assign hit              = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign bus.btb_hit      = hit;
  assign bus.pred_jump    = hit && bus.predict_taken;
  assign bus.pred_target  = hit ? target_q[if_idx] : '0;

  // Only taken branches allocate; not-taken resolutions leave the table alone.
  assign wr_en = bus.ex_is_br && bus.br_ex;

  // Wrong direction, or right "taken" direction but stale target.
  assign dir_wrong       = bus.ex_pred_jump != bus.br_ex;
  assign tgt_wrong       = bus.ex_pred_jump && bus.br_ex && (bus.ex_pred_target != bus.br_target_ex);
  assign mispredict      = bus.ex_is_br && (dir_wrong || tgt_wrong);
  assign bus.mispredict  = mispredict;
  assign bus.redirect_pc = !mispredict ? '0 :
                           bus.br_ex   ? bus.br_target_ex :
                                         bus.pc_ex + PC_LEN'(4);

  // Next valid vector: allocate on taken branch, flash clear overrides it.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[ex_idx] = 1'b1;
    end
    if (bus.btb_clear) begin
      valid_d = '0;
    end
  end

  // Valid bits with asynchronous clear so lookups miss immediately in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag/target storage; a write during reset is harmless because valid stays 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= bus.br_target_ex;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] br_cnt_d;
  logic [31:0] miss_cnt_q;
  logic [31:0] miss_cnt_d;

  // Counters wrap naturally and ignore flash clear.
  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bus.ex_is_br) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end
    if (mispredict) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign stat_br_cnt   = br_cnt_q;
  assign stat_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - self-checking bench for branch_target_buffer
module tb_branch_target_buffer;

  localparam int AL  = 7;
  localparam int ENT = 1 << AL;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  branch_target_buffer_if #(.PC_LEN(32)) bus();

`ifdef BTB_STATS_EN
  logic [31:0] stat_br_cnt;
  logic [31:0] stat_miss_cnt;
`endif

  branch_target_buffer #(.BTB_ADDR_LEN(AL), .PC_LEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef BTB_STATS_EN
    ,
    .stat_br_cnt   (stat_br_cnt),
    .stat_miss_cnt (stat_miss_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: per index, the full PC and target of the last taken branch.
  bit          m_valid [ENT];
  logic [31:0] m_pc    [ENT];
  logic [31:0] m_tgt   [ENT];
  logic [31:0] m_br;
  logic [31:0] m_miss;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return m_valid[i] && ((m_pc[i] >> (AL + 2)) == (pc >> (AL + 2)));
  endfunction

  function automatic logic [31:0] m_target(logic [31:0] pc);
    return m_hit(pc) ? m_tgt[idx_of(pc)] : 32'h0;
  endfunction

  function automatic bit m_mis();
    if (!bus.ex_is_br) return 1'b0;
    if (bus.ex_pred_jump != bus.br_ex) return 1'b1;
    return bus.br_ex && (bus.ex_pred_target != bus.br_target_ex);
  endfunction

  function automatic logic [31:0] m_redirect();
    if (!m_mis()) return 32'h0;
    return bus.br_ex ? bus.br_target_ex : bus.pc_ex + 32'd4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
      m_br   = 32'h0;
      m_miss = 32'h0;
    end else begin
      if (bus.ex_is_br) m_br = m_br + 32'd1;
      if (m_mis()) m_miss = m_miss + 32'd1;
      if (bus.btb_clear) begin
        for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
      end else if (bus.ex_is_br && bus.br_ex) begin
        m_valid[idx_of(bus.pc_ex)] = 1'b1;
        m_pc[idx_of(bus.pc_ex)]    = bus.pc_ex;
        m_tgt[idx_of(bus.pc_ex)]   = bus.br_target_ex;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  bit cmp_en;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_hit",       32'(bus.btb_hit),    32'(m_hit(bus.pc_if)));
      chk("cmp_pred_jump", 32'(bus.pred_jump),  32'(m_hit(bus.pc_if) && bus.predict_taken));
      chk("cmp_target",    bus.pred_target,     m_target(bus.pc_if));
      chk("cmp_mispred",   32'(bus.mispredict), 32'(m_mis()));
      chk("cmp_redirect",  bus.redirect_pc,     m_redirect());
`ifdef BTB_STATS_EN
      chk("cmp_stat_br",   stat_br_cnt,   m_br);
      chk("cmp_stat_miss", stat_miss_cnt, m_miss);
`endif
    end
  end

  task automatic idle_ex();
    bus.ex_is_br       = 1'b0;
    bus.pc_ex          = 32'h0;
    bus.br_ex          = 1'b0;
    bus.br_target_ex   = 32'h0;
    bus.ex_pred_jump   = 1'b0;
    bus.ex_pred_target = 32'h0;
    bus.btb_clear      = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle_ex();
  endtask

  task automatic resolve(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                         input bit pj, input logic [31:0] pt);
    bus.ex_is_br       = 1'b1;
    bus.pc_ex          = pc;
    bus.br_ex          = taken;
    bus.br_target_ex   = tgt;
    bus.ex_pred_jump   = pj;
    bus.ex_pred_target = pt;
  endtask

  initial begin
    logic [31:0] rpc;
    checks   = 0;
    failures = 0;
    cmp_en   = 1'b0;
    rst_n    = 1'b0;
    idle_ex();
    bus.pc_if         = 32'h100;
    bus.predict_taken = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hit", 32'(bus.btb_hit), 32'h0);
    chk("rst_target", bus.pred_target, 32'h0);
    rst_n = 1'b1;
    #2;
    chk("r033_hit", 32'(bus.btb_hit), 32'h0);
    chk("r033_pj", 32'(bus.pred_jump), 32'h0);
    chk("r033_pt", bus.pred_target, 32'h0);

    next();
    resolve(32'h100, 1'b1, 32'h40, 1'b0, 32'h0);
    #2;
    chk("r034_mis", 32'(bus.mispredict), 32'h1);
    chk("r034_red", bus.redirect_pc, 32'h40);
    chk("r034_nobypass", 32'(bus.btb_hit), 32'h0);
    next();
    #2;
    chk("r034_hit", 32'(bus.btb_hit), 32'h1);
    chk("r034_pj", 32'(bus.pred_jump), 32'h1);
    chk("r034_pt", bus.pred_target, 32'h40);

    resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h40);
    #2;
    chk("r035_mis", 32'(bus.mispredict), 32'h1);
    chk("r035_red", bus.redirect_pc, 32'h104);
    next();
    #2;
    chk("r035_keep", 32'(bus.btb_hit), 32'h1);

    resolve(32'h100, 1'b1, 32'h40, 1'b1, 32'h40);
    #2;
    chk("ok_mis", 32'(bus.mispredict), 32'h0);
    chk("ok_red", bus.redirect_pc, 32'h0);
    next();

    resolve(32'h300, 1'b1, 32'h80, 1'b0, 32'h0);
    next();
    #2;
    chk("r036_old_miss", 32'(bus.btb_hit), 32'h0);
    bus.pc_if = 32'h300;
    #1;
    chk("r036_new_hit", 32'(bus.btb_hit), 32'h1);
    chk("r036_new_pt", bus.pred_target, 32'h80);

    resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
    #2;
    chk("wrap_red", bus.redirect_pc, 32'h0);
    next();

    resolve(32'h100, 1'b1, 32'h44, 1'b1, 32'h40);
    #2;
    chk("tgt_mis", 32'(bus.mispredict), 32'h1);
    chk("tgt_red", bus.redirect_pc, 32'h44);
    next();

    resolve(32'h200, 1'b1, 32'h10, 1'b0, 32'h0);
    bus.btb_clear = 1'b1;
    next();
    bus.pc_if = 32'h100;
    #2;
    chk("r037_miss100", 32'(bus.btb_hit), 32'h0);
    bus.pc_if = 32'h200;
    #1;
    chk("r037_miss200", 32'(bus.btb_hit), 32'h0);

    resolve(32'h100, 1'b1, 32'h20, 1'b0, 32'h0);
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    bus.pc_if = 32'h100;
    #2;
    chk("r029_lost", 32'(bus.btb_hit), 32'h0);
    resolve(32'h100, 1'b1, 32'h24, 1'b0, 32'h0);
    next();
    #2;
    chk("r029_first_pt", bus.pred_target, 32'h24);

`ifdef BTB_STATS_EN
    rst_n = 1'b0;
    #2;
    chk("stat_rst_br", stat_br_cnt, 32'h0);
    next();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      resolve(32'h400 + 32'(k * 4), 1'b0, 32'h0, (k == 0) || (k == 3), 32'h0);
      next();
    end
    #2;
    chk("r038_br", stat_br_cnt, 32'd5);
    chk("r038_miss", stat_miss_cnt, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("r038_rst_br", stat_br_cnt, 32'h0);
    chk("r038_rst_miss", stat_miss_cnt, 32'h0);
    next();
    rst_n = 1'b1;
`endif

    for (int c = 0; c < 3000; c++) begin
      bus.pc_if = ($urandom_range(0, 7) << 9) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      bus.predict_taken = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        rpc = ($urandom_range(0, 7) << 9) | ($urandom_range(0, 15) << 2);
        if ($urandom_range(0, 1) == 1) begin
          resolve(rpc, 1'($urandom), $urandom & 32'hFFFF_FFFC,
                  m_hit(rpc) && 1'($urandom), m_target(rpc));
        end else begin
          resolve(rpc, 1'($urandom), $urandom_range(0, 3) << 4, 1'($urandom), $urandom_range(0, 3) << 4);
        end
      end
      bus.btb_clear = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_ex();
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
